// File: rtl/sram_write_arbiter.sv
// Round-robin arbiter for the single write port of a block SRAM.
// After reset or clear_start it writes CLEAR_VALUE to every address before any client is granted.
module sram_write_arbiter #(
    parameter int                    NUM_REQUESTERS = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SIZE           = 1024,
    parameter int                    ADDR_WIDTH     = $clog2(SIZE),
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clear_start,
    input  logic [NUM_REQUESTERS-1:0]            wr_request,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REQUESTERS-1:0]            wr_grant,
    output logic                                 init_done,
    output logic                                 sram_write_en,
    output logic [ADDR_WIDTH-1:0]                sram_write_addr,
    output logic [DATA_WIDTH-1:0]                sram_write_data
);
    localparam int PTR_W = $clog2(NUM_REQUESTERS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);
    localparam logic [PTR_W-1:0]      LAST_REQ  = PTR_W'(NUM_REQUESTERS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                                       state, state_nxt;
    logic [ADDR_WIDTH-1:0]                        clear_addr;
    logic [PTR_W-1:0]                             rr_ptr;
    logic [PTR_W-1:0]                             grant_idx;
    logic [PTR_W-1:0]                             cand;
    logic                                         grant_any;
    logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0]    req_addr;
    logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]    req_data;

    assign req_addr = wr_addr;
    assign req_data = wr_data;

    // Scan from rr_ptr upward with wrap; the first requester found wins.
    always_comb begin
        wr_grant  = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state == RUN && !clear_start) begin
            for (int k = 0; k < NUM_REQUESTERS; k++) begin
                cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQUESTERS);
                if (!grant_any && wr_request[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) wr_grant[grant_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clear_addr == LAST_ADDR) state_nxt = RUN;
            RUN:     if (clear_start) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= CLEAR;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clear_addr      <= '0;
            rr_ptr          <= '0;
            init_done       <= 1'b0;
            sram_write_en   <= 1'b0;
            sram_write_addr <= '0;
            sram_write_data <= '0;
        end else if (state == CLEAR) begin
            sram_write_en   <= 1'b1;
            sram_write_addr <= clear_addr;
            sram_write_data <= CLEAR_VALUE;
            clear_addr      <= clear_addr + 1'b1;
            if (clear_addr == LAST_ADDR) init_done <= 1'b1;
        end else if (clear_start) begin
            clear_addr    <= '0;
            init_done     <= 1'b0;
            sram_write_en <= 1'b0;
        end else if (grant_any) begin
            sram_write_en   <= 1'b1;
            sram_write_addr <= req_addr[grant_idx];
            sram_write_data <= req_data[grant_idx];
            rr_ptr          <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        end else begin
            // Idle RUN cycle: address and data hold their last values.
            sram_write_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sram_write_arbiter.sv
// Randomized bench for sram_write_arbiter against a cycle-level model of the arbitration and clear rules.
module tb_sram_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SZ = 16;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              clear_start = 1'b0;
    logic [N-1:0]      wr_request = '0;
    logic [N*AW-1:0]   wr_addr = '0;
    logic [N*DW-1:0]   wr_data = '0;
    logic [N-1:0]      wr_grant;
    logic              init_done;
    logic              sram_write_en;
    logic [AW-1:0]     sram_write_addr;
    logic [DW-1:0]     sram_write_data;

    sram_write_arbiter #(
        .NUM_REQUESTERS(N), .DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW), .CLEAR_VALUE('0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear_start(clear_start),
        .wr_request(wr_request), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_grant(wr_grant), .init_done(init_done),
        .sram_write_en(sram_write_en), .sram_write_addr(sram_write_addr),
        .sram_write_data(sram_write_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // client side
    bit            pend [N];
    logic [AW-1:0] ca   [N];
    logic [DW-1:0] cd   [N];
    logic [N-1:0]  allow;
    int            prob;
    int            mode;

    // reference model
    bit            m_valid = 0;
    bit            m_clearing;
    int            m_caddr;
    int            m_ptr;
    bit            m_done;
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input bit clr);
        if (m_clearing || clr) return -1;
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input bit rst, input bit clr);
        int g;
        logic [N-1:0] eg;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && allow[i] && $urandom_range(99) < prob) begin
                pend[i] = 1;
                if (mode == 1) begin
                    ca[i] = AW'(8 + i);
                    cd[i] = DW'(32'hA0 + i);
                end else begin
                    ca[i] = AW'($urandom);
                    cd[i] = $urandom;
                end
            end
            wr_request[i]          = pend[i];
            wr_addr[i*AW +: AW]    = ca[i];
            wr_data[i*DW +: DW]    = cd[i];
        end
        reset_n     = rst;
        clear_start = clr;
        g  = model_grant(clr);
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        #1;
        if (m_valid) begin
            chk("grant", 64'(wr_grant), 64'(eg));
            chk("init_done", 64'(init_done), 64'(m_done));
            chk("wen", 64'(sram_write_en), 64'(m_en));
            chk("waddr", 64'(sram_write_addr), 64'(m_addr));
            chk("wdata", 64'(sram_write_data), 64'(m_data));
        end
        @(posedge clk);
        if (!rst) begin
            m_valid = 1; m_clearing = 1; m_caddr = 0; m_ptr = 0;
            m_done = 0; m_en = 0; m_addr = '0; m_data = '0;
        end else if (m_clearing) begin
            m_en = 1; m_addr = AW'(m_caddr); m_data = '0;
            if (m_caddr == SZ - 1) begin
                m_clearing = 0; m_done = 1;
            end else m_caddr++;
        end else if (clr) begin
            m_clearing = 1; m_caddr = 0; m_done = 0; m_en = 0;
        end else if (g >= 0) begin
            m_en = 1; m_addr = ca[g]; m_data = cd[g];
            m_ptr = (g + 1) % N;
            pend[g] = 0;
        end else m_en = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; ca[i] = '0; cd[i] = '0;
        end
        // reset clear with all clients requesting, then full contention
        allow = 4'b1111; prob = 100; mode = 1;
        cycle(0, 0);
        cycle(0, 0);
        repeat (SZ + 10) cycle(1, 0);
        // drain, then single requester back-to-back
        allow = 4'b0000; mode = 0;
        repeat (6) cycle(1, 0);
        allow = 4'b0100;
        repeat (4) cycle(1, 0);
        allow = 4'b0000;
        repeat (3) cycle(1, 0);
        // pointer wrap: client 3, then 0 and 3 together
        allow = 4'b1000;
        repeat (2) cycle(1, 0);
        allow = 4'b1001;
        repeat (5) cycle(1, 0);
        allow = 4'b0000;
        repeat (4) cycle(1, 0);
        // re-clear while client 1 requests
        allow = 4'b0010;
        cycle(1, 0);
        cycle(1, 1);
        repeat (SZ + 4) cycle(1, 0);
        // reset when clear address 7 is on the outputs
        cycle(1, 1);
        for (int n = 0; n < 40 && !(m_clearing && m_en && m_addr == 7); n++) cycle(1, 0);
        chk("reach_addr7", 64'(m_clearing && m_en && m_addr == 7), 64'd1);
        cycle(0, 0);
        repeat (SZ + 6) cycle(1, 0);
        // random traffic with occasional clears and resets
        allow = 4'b1111; prob = 40;
        repeat (600) cycle($urandom_range(199) != 0, $urandom_range(99) == 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_write_arbiter.md
Name: sram_write_arbiter

Overview:
- Shares the single write port of a 2-read/1-write block SRAM among NUM_REQUESTERS clients using round-robin arbitration.
- The SRAM does not clear its contents on reset, so this block also runs a hardware clear sequence. The sequence runs after reset and on demand, and writes CLEAR_VALUE to every address before any client is granted.
- Sits between the clients and the SRAM write port. Read ports are not touched.

Parameters:
- NUM_REQUESTERS, 4: number of write clients; must be 2 or more.
- DATA_WIDTH, 32: SRAM word width.
- SIZE, 1024: SRAM depth; need not be a power of two.
- ADDR_WIDTH, $clog2(SIZE): address width.
- CLEAR_VALUE, 0: word written to every address during a clear (DATA_WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- clear_start  input  1  pulse that requests a full re-clear.
- wr_request  input  NUM_REQUESTERS  per-client write request.
- wr_addr  input  NUM_REQUESTERS*ADDR_WIDTH  client addresses, flattened; client i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data  input  NUM_REQUESTERS*DATA_WIDTH  client data, flattened the same way.
- wr_grant  output  NUM_REQUESTERS  one-hot or zero; combinational.
- init_done  output  1  high when no clear is in progress and grants are possible.
- sram_write_en  output  1  registered; drives the SRAM write_en.
- sram_write_addr  output  ADDR_WIDTH  registered; drives the SRAM write_addr.
- sram_write_data  output  DATA_WIDTH  registered; drives the SRAM write_data.

Behaviour:
- Reset:
  - Reset is synchronous and active-low; clk is the only clock.
  - While reset_n=0 at an edge, the block loads: state=CLEAR, clear_addr=0, rr_ptr=0, init_done=0, sram_write_en=0, sram_write_addr=0, sram_write_data=0.
  - wr_grant=0 whenever state=CLEAR.
- CLEAR state:
  - Every edge registers sram_write_en=1, sram_write_addr=clear_addr, sram_write_data=CLEAR_VALUE, then clear_addr increments.
  - The edge that issues clear_addr==SIZE-1 also sets state=RUN and init_done=1.
  - Timing: if edge 0 is the first edge with reset_n=1, clear writes appear on the outputs after edges 0..SIZE-1. init_done is 1 from edge SIZE-1 onward. The first grant is possible in the cycle after edge SIZE-1.
  - Requests are ignored; wr_grant=0.
  - clear_start is ignored.
  - Reset asserted mid-clear restarts the sequence at address 0.
- RUN state, arbitration:
  - wr_grant is combinational from state, rr_ptr, wr_request and clear_start.
  - Search order: rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQUESTERS. The first client with its request bit set is granted.
  - At most one grant bit is set.
  - If clear_start=1, wr_grant is forced to 0 for that cycle.
- RUN state, on grant to client i at an edge:
  - The edge registers sram_write_en=1, sram_write_addr=wr_addr[i], sram_write_data=wr_data[i].
  - rr_ptr becomes (i+1) mod NUM_REQUESTERS.
  - Write latency is 1 cycle from grant to SRAM port; the SRAM commits it one edge later.
- RUN state, other edges:
  - No grant: sram_write_en=0; addr and data hold their previous values; rr_ptr unchanged.
  - clear_start=1 at an edge: state=CLEAR, clear_addr=0, init_done=0, sram_write_en=0. The first clear write appears one edge later.
- Client protocol:
  - Client i holds wr_request[i], wr_addr[i] and wr_data[i] stable until it sees wr_grant[i]=1 at an edge.
  - A grant consumes exactly one request; the client deasserts, or presents its next write, the following cycle.
  - A continuously requesting client gets back-to-back writes only if no other client is requesting.
- Fairness: any requester waits at most NUM_REQUESTERS-1 grants.
- No read-side interaction. Read-during-write bypass remains the responsibility of the SRAM.

Test Plan:
- Reset clear:
  - Stimulus: SIZE=16, release reset_n with wr_request=4'b1111 held.
  - Required: 16 consecutive writes, addr 0..15, data 0. init_done=1 from the edge carrying addr 15. wr_grant=0 throughout. First grant to client 0 in the next cycle.
- Full contention:
  - Stimulus: after init, all 4 clients request continuously; client i uses addr 8+i, data 32'hA0+i.
  - Required: grants 0,1,2,3,0,1. sram_write_addr 8,9,10,11,8,9, each one cycle after its grant; sram_write_en stays 1.
- Single requester:
  - Stimulus: only client 2 requests, 3 back-to-back writes to addr 5,6,7.
  - Required: wr_grant=4'b0100 every cycle; SRAM writes to 5,6,7 on consecutive cycles; rr_ptr ends at 3.
- Pointer wrap:
  - Stimulus: grant to client 3, then clients 0 and 3 request.
  - Required: client 0 granted next, then client 3.
- Re-clear:
  - Stimulus: in RUN, clear_start pulse while client 1 requests.
  - Required: no grant that cycle; init_done=0 next edge; sram_write_en=0 for one cycle; then 16 clear writes, addr 0..15. Client 1 is granted after init_done returns to 1.
- Reset mid-clear:
  - Stimulus: assert reset_n=0 for one edge when clear addr 7 is on the outputs.
  - Required: sram_write_en=0 for that edge; clear restarts at addr 0; 16 full writes; init_done timing as in the reset-clear scenario.
